// File: rtl/target_encoder.sv
// target_encoder: small register table of targets with a sequential
// reverse lookup. A request target is compared against one entry per cycle
// starting at index 0; the first (lowest) matching index is returned, or a
// miss after the last entry. The table can be rewritten at any time.
module target_encoder #(
    parameter int ENTRIES = 4,
    parameter int ADDR_W  = 2,
    parameter int TGT_W   = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [TGT_W-1:0]  WrData,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [TGT_W-1:0]  ReqTarget,
    output logic              RspValid,
    input  logic              RspReady,
    output logic              RspHit,
    output logic [ADDR_W-1:0] RspAddr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Power-up contents of each entry: -1, 3, 7, then 1 for the rest.
    function automatic logic [TGT_W-1:0] rst_val(input int idx);
        case (idx)
            0:       rst_val = '1;
            1:       rst_val = TGT_W'(32'd3);
            2:       rst_val = TGT_W'(32'd7);
            default: rst_val = TGT_W'(32'd1);
        endcase
    endfunction

    state_t                          r_state;
    logic [ADDR_W-1:0]               r_cnt;
    logic [TGT_W-1:0]                r_tgt;
    logic                            r_rsp_valid;
    logic                            r_rsp_hit;
    logic [ADDR_W-1:0]               r_rsp_addr;
    logic [ENTRIES-1:0][TGT_W-1:0]   r_table;

    logic [TGT_W-1:0]                w_cur;
    logic                            w_match;
    logic                            w_last;

    // Out-of-range addresses match no entry, so such writes fall away.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        // Table entry i: written whenever addressed, regardless of FSM state.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n)
                r_table[i] <= rst_val(i);
            else if (WrEn && (WrAddr == ADDR_W'(i)))
                r_table[i] <= WrData;
        end
    end

    // The compare sees the table as registered at the start of the cycle, so
    // a same-cycle write to the compared entry only affects later lookups.
    assign w_cur   = r_table[r_cnt];
    assign w_match = (w_cur == r_tgt);
    assign w_last  = (r_cnt == ADDR_W'(ENTRIES - 1));

    // Lookup FSM: accept in IDLE, walk entries in SEARCH, hold result in RESP.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tgt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ReqValid) begin
                        r_tgt   <= ReqTarget;
                        r_cnt   <= '0;
                        r_state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (w_match) begin
                        r_rsp_hit   <= 1'b1;
                        r_rsp_addr  <= r_cnt;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_last) begin
                        r_rsp_hit   <= 1'b0;
                        r_rsp_addr  <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                S_RESP: begin
                    // No new accept on the handshake edge; IDLE comes first.
                    if (RspReady) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign ReqReady = (r_state == S_IDLE);
    assign RspValid = r_rsp_valid;
    assign RspHit   = r_rsp_hit;
    assign RspAddr  = r_rsp_addr;

endmodule

// File: doc/target_encoder.md
TARGET_ENCODER -- requirements
Module: target_encoder

Interface
REQ-001 SHALL provide parameter ENTRIES, default 4: number of table entries, >= 2.
REQ-002 SHALL provide parameter ADDR_W, default 2: index width, equal to ceil(log2(ENTRIES)).
REQ-003 SHALL provide parameter TGT_W, default 10: target width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port Clk, input, 1: clock; all state changes on the rising edge.
REQ-006 SHALL have port Reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port WrEn, input, 1: write the table entry at WrAddr.
REQ-008 SHALL have port WrAddr, input, ADDR_W: index of the entry to write.
REQ-009 SHALL have port WrData, input, TGT_W: target value to store.
REQ-010 SHALL have port ReqValid, input, 1: lookup request present.
REQ-011 SHALL have port ReqReady, output, 1: block can accept a request.
REQ-012 SHALL have port ReqTarget, input, TGT_W: target to reverse-map to an index.
REQ-013 SHALL have port RspValid, output, 1: response present.
REQ-014 SHALL have port RspReady, input, 1: consumer accepts the response.
REQ-015 SHALL have port RspHit, output, 1: the target was found.
REQ-016 SHALL have port RspAddr, output, ADDR_W: lowest matching index; 0 on miss.

Function
REQ-017 SHALL hold a table of ENTRIES x TGT_W registers with reset values: entry0 = all ones (-1), entry1 = 3, entry2 = 7, all other entries = 1, zero-extended or truncated to TGT_W.
REQ-018 SHALL write WrData into entry WrAddr on a clock edge when WrEn = 1, in any FSM state.
REQ-019 SHALL ignore writes with WrAddr >= ENTRIES.
REQ-020 SHALL implement FSM states IDLE, SEARCH and RESP.
REQ-021 SHALL drive ReqReady = 1 only in IDLE, decoded from the state register only.
REQ-022 SHALL, in IDLE when ReqValid = 1, capture ReqTarget, clear the index counter to 0 and enter SEARCH.
REQ-023 SHALL, in SEARCH, compare one entry per cycle (the entry at the counter) against the captured target, using the table contents registered at the start of that cycle.
REQ-024 SHALL, on a SEARCH match, load RspHit = 1 and RspAddr = counter, then enter RESP.
REQ-025 SHALL, on a SEARCH mismatch with counter = ENTRIES-1, load RspHit = 0 and RspAddr = 0, then enter RESP.
REQ-026 SHALL otherwise increment the counter and remain in SEARCH.
REQ-027 SHALL give RspValid = 1 after edge E(k+1) for a hit at index k, and after edge E(ENTRIES) for a miss, where E0 is the request-accept edge.
REQ-028 SHALL return the lowest index when several entries match.
REQ-029 SHALL make a write to an entry that has already been compared have no effect on the in-flight result; a write to the entry compared in the same cycle takes effect only for later lookups.
REQ-030 SHALL drive RspValid = 1 only in RESP.
REQ-031 SHALL hold RspHit and RspAddr stable while RspValid = 1 and RspReady = 0.
REQ-032 SHALL, in RESP when RspReady = 1, return to IDLE.
REQ-033 SHALL NOT accept a new request in the same cycle as a response handshake; the minimum request-to-request spacing is therefore k+3 cycles.
REQ-034 SHALL ignore ReqValid and ReqTarget outside IDLE.

Reset
REQ-035 SHALL, while Reset_n = 0, asynchronously force state = IDLE, counter = 0, RspValid = 0, RspHit = 0, RspAddr = 0, and all table entries to the values in REQ-017.
REQ-036 SHALL, on reset asserted mid-SEARCH or mid-RESP, discard the in-flight request with no response.
REQ-037 SHALL give ReqReady = 1 in the first cycle after Reset_n deasserts.

Verification
REQ-038 SHALL test a reset-default hit: ReqTarget = 10'h007 with RspReady = 1 -> RspValid after E3, RspHit = 1, RspAddr = 2.
REQ-039 SHALL test a miss: ReqTarget = 10'h155 -> RspValid after E4, RspHit = 0, RspAddr = 0.
REQ-040 SHALL test duplicates and writes: write entry3 = 10'h003, then ReqTarget = 10'h003 -> RspAddr = 1; then write entry1 = 10'h000, ReqTarget = 10'h003 -> RspAddr = 3.
REQ-041 SHALL test backpressure: hold RspReady = 0 for 5 cycles after RspValid -> RspValid, RspHit and RspAddr are stable and ReqReady = 0; ReqReady returns to 1 one cycle after RspReady = 1.
REQ-042 SHALL test a concurrent write: during SEARCH at counter 1, write entry0 = ReqTarget -> the result is unaffected; an identical follow-up request -> RspAddr = 0.
REQ-043 SHALL test reset mid-operation: drive Reset_n low during SEARCH -> no RspValid, the table is restored (ReqTarget = 10'h3FF -> RspAddr = 0).
